// File: rtl/pipe_ctrl.sv
// Hazard and status controller for a five-stage Y86-64 pipeline: per-stage stall/bubble
// controls, first-exception latch with freeze, and saturating hazard performance counters.
module pipe_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             halted,
  output logic [2:0]       cpu_stat,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [CNT_W-1:0] misp_cnt,
  output logic [CNT_W-1:0] ret_cnt
);

  // state    | meaning
  // S_RUN    | normal operation, hazard logic drives the pipeline controls
  // S_HALTED | exception reached W; pipeline frozen until reset

  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPOPQ   = 4'hB;
  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [2:0] SAOK    = 3'd1;
  localparam logic [2:0] SHLT    = 3'd2;
  localparam logic [2:0] SADR    = 3'd3;
  localparam logic [2:0] SINS    = 3'd4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    S_RUN    = 1'b0,
    S_HALTED = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_init;
  logic [2:0]       r_cpu_stat;
  logic [CNT_W-1:0] r_cyc_cnt;
  logic [CNT_W-1:0] r_lu_cnt;
  logic [CNT_W-1:0] r_misp_cnt;
  logic [CNT_W-1:0] r_ret_cnt;

  logic w_lu;
  logic w_mp;
  logic w_rt;
  logic w_m_err;
  logic w_w_err;
  logic w_run;

  function automatic logic f_err(input logic [2:0] s);
    return (s == SHLT) || (s == SADR) || (s == SINS);
  endfunction

  function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != CNT_MAX)) ? v + 1'b1 : v;
  endfunction

  assign w_lu = ((E_icode == IMRMOVQ) || (E_icode == IPOPQ)) && (E_dstM != RNONE) &&
                ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign w_mp = (E_icode == IJXX) && !e_Cnd;
  assign w_rt = (D_icode == IRET) || (E_icode == IRET) || (M_icode == IRET);
  assign w_m_err = f_err(m_stat);
  assign w_w_err = f_err(W_stat);
  assign w_run   = (r_state == S_RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:    if (w_w_err) w_state_nxt = S_HALTED;
      S_HALTED: w_state_nxt = S_HALTED;
      default:  w_state_nxt = S_RUN;
    endcase
  end

  // Flush pattern holds from reset assertion until the first edge after release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_init <= 1'b1;
    end else begin
      r_init <= 1'b0;
    end
  end

  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    W_stall  = 1'b0;
    if (reset || r_init) begin
      D_bubble = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
    end else begin
      case (r_state)
        S_HALTED: begin
          F_stall  = 1'b1;
          D_stall  = 1'b1;
          E_bubble = 1'b1;
          M_bubble = 1'b1;
          W_stall  = 1'b1;
        end
        default: begin
          F_stall  = w_lu | w_rt;
          D_stall  = w_lu;
          D_bubble = w_mp | (w_rt & !w_lu);
          E_bubble = w_mp | w_lu;
          M_bubble = w_m_err | w_w_err;
          W_stall  = w_w_err;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cpu_stat <= SAOK;
    end else if (w_run && w_w_err) begin
      r_cpu_stat <= W_stat;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cyc_cnt  <= '0;
      r_lu_cnt   <= '0;
      r_misp_cnt <= '0;
      r_ret_cnt  <= '0;
    end else if (w_run) begin
      r_cyc_cnt  <= f_sat_inc(r_cyc_cnt, 1'b1);
      r_lu_cnt   <= f_sat_inc(r_lu_cnt, w_lu);
      r_misp_cnt <= f_sat_inc(r_misp_cnt, w_mp);
      r_ret_cnt  <= f_sat_inc(r_ret_cnt, w_rt & !w_lu);
    end
  end

  assign halted   = (r_state == S_HALTED);
  assign cpu_stat = r_cpu_stat;
  assign cyc_cnt  = r_cyc_cnt;
  assign lu_cnt   = r_lu_cnt;
  assign misp_cnt = r_misp_cnt;
  assign ret_cnt  = r_ret_cnt;

endmodule
